serial_parity_checker: RTL

- Serial-in frame receiver that rebuilds a DATA_W-bit word from a bit stream, one bit per qualified clock, LSB first.
- Folds every received bit into a running XOR, then checks it against a trailing parity bit.
- Sits directly downstream of the XOR gate/parity-generation stage in the link datapath.
- Presents the word and its parity verdict on a valid/ready output port to the next consumer.

---
 rtl/serial_parity_checker.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/serial_parity_checker.sv
// serial_parity_checker
// Rebuilds a DATA_W-bit word from an LSB-first serial bit stream, folds every
// bit into a running XOR and checks it against the trailing parity bit. The
// finished word and its parity verdict are offered on a valid/ready port.
//
// Optional build macro: PARITY_ERR_CNT_EN
//   defined   -> err_cnt counts handshaken bad-parity frames, saturating at 255
//   undefined -> err_cnt is tied to zero and no counter is built
module serial_parity_checker #(
  parameter int DATA_W     = 8,
  parameter int ODD_PARITY = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_in,
  input  logic              bit_valid,
  input  logic              bit_sof,
  output logic [DATA_W-1:0] out_data,
  output logic              out_parity_ok,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_overrun,
  output logic              busy,
  output logic [7:0]        err_cnt
);

  localparam int CW = $clog2(DATA_W + 1);

  // Value of cnt while the last data bit of the frame is being received.
  localparam logic [CW-1:0] LAST_CNT = CW'(DATA_W - 1);

  // Required XOR of all data bits plus the parity bit.
  localparam logic ODD_BIT = (ODD_PARITY != 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // A one-bit frame has no further data bits, so the next bit is parity.
  localparam state_t FIRST_NEXT = (DATA_W == 1) ? PAR : SHIFT;

  state_t            state;
  state_t            state_next;

  logic [DATA_W-1:0] shift_reg;
  logic [CW-1:0]     cnt;
  logic              acc;

  logic              start_frame;
  logic              shift_bit;
  logic              capture;
  logic              drop_bit;
  logic              handshake;

  // Shifting right with the new bit entering at the top leaves the first
  // received bit at position 0 once DATA_W bits have arrived.
  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] cur,
                                                 input logic b);
    logic [DATA_W:0] tmp;
    tmp = {b, cur};
    return tmp[DATA_W:1];
  endfunction

  assign handshake = (state == HOLD) && out_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; also names the datapath action for this cycle.
  always_comb begin
    state_next  = state;
    start_frame = 1'b0;
    shift_bit   = 1'b0;
    capture     = 1'b0;
    drop_bit    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bit_valid && bit_sof) begin
          start_frame = 1'b1;
          state_next  = FIRST_NEXT;
        end
      end
      SHIFT: begin
        if (bit_valid) begin
          if (bit_sof) begin
            start_frame = 1'b1;
            state_next  = FIRST_NEXT;
          end else begin
            shift_bit = 1'b1;
            if (cnt == LAST_CNT) begin
              state_next = PAR;
            end
          end
        end
      end
      PAR: begin
        if (bit_valid) begin
          if (bit_sof) begin
            start_frame = 1'b1;
            state_next  = FIRST_NEXT;
          end else begin
            capture    = 1'b1;
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        if (handshake) begin
          state_next = IDLE;
        end else if (bit_valid) begin
          drop_bit = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs decoded purely from the current state.
  always_comb begin
    busy      = (state != IDLE);
    out_valid = (state == HOLD);
  end

  // Frame assembly, parity accumulation, result capture and sticky overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg     <= '0;
      cnt           <= '0;
      acc           <= 1'b0;
      out_data      <= '0;
      out_parity_ok <= 1'b0;
      out_overrun   <= 1'b0;
    end else begin
      if (start_frame) begin
        shift_reg <= shift_in('0, bit_in);
        acc       <= bit_in;
        cnt       <= CW'(1);
      end else if (shift_bit) begin
        shift_reg <= shift_in(shift_reg, bit_in);
        acc       <= acc ^ bit_in;
        cnt       <= cnt + CW'(1);
      end else if (capture) begin
        out_data      <= shift_reg;
        out_parity_ok <= ((acc ^ bit_in) == ODD_BIT);
        cnt           <= '0;
        acc           <= 1'b0;
      end

      if (handshake) begin
        out_overrun <= 1'b0;
      end else if (drop_bit) begin
        out_overrun <= 1'b1;
      end
    end
  end

`ifdef PARITY_ERR_CNT_EN
  // Count bad-parity words as they are handed over, holding at 255.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= 8'd0;
    end else if (handshake && !out_parity_ok && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`else
  assign err_cnt = 8'd0;
`endif

endmodule
